// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB operand forwarding.
// Latency: one cycle from decode inputs to A/B/control outputs; forwarding and Hazard_Stall are combinational.
// Backpressure: Stall holds the stage, Flush squashes it, Hazard_Stall inserts a bubble and holds upstream.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int OP_SZ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             In_Valid,
  input  logic [4:0]       Rs_Addr,
  input  logic [4:0]       Rt_Addr,
  input  logic [4:0]       Rd_Addr,
  input  logic [WIDTH-1:0] Rs_Data,
  input  logic [WIDTH-1:0] Rt_Data,
  input  logic [WIDTH-1:0] Imm,
  input  logic             Use_Imm,
  input  logic [OP_SZ-1:0] ALU_Sel_In,
  input  logic             Reg_Write_In,
  input  logic             Mem_Read_In,
  input  logic             EXMEM_RegWrite,
  input  logic [4:0]       EXMEM_Rd,
  input  logic [WIDTH-1:0] EXMEM_Result,
  input  logic             MEMWB_RegWrite,
  input  logic [4:0]       MEMWB_Rd,
  input  logic [WIDTH-1:0] MEMWB_Result,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OP_SZ-1:0] ALU_Sel,
  output logic [4:0]       Rd_Out,
  output logic             Reg_Write_Out,
  output logic             Mem_Read_Out,
  output logic             Valid_Out,
  output logic             Hazard_Stall
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             use_imm;
    logic [OP_SZ-1:0] alu_sel;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;
  logic load_use;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = In_Valid;
    ex_d.reg_write = Reg_Write_In;
    ex_d.mem_read  = Mem_Read_In;
    ex_d.use_imm   = Use_Imm;
    ex_d.alu_sel   = ALU_Sel_In;
    ex_d.rs        = Rs_Addr;
    ex_d.rt        = Rt_Addr;
    ex_d.rd        = Rd_Addr;
    ex_d.rs_data   = Rs_Data;
    ex_d.rt_data   = Rt_Data;
    ex_d.imm       = Imm;
  end

  // A load in EX whose destination feeds the decoding instruction cannot be forwarded in time.
  assign load_use = In_Valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == Rs_Addr) | ((ex_q.rd == Rt_Addr) & ~Use_Imm));
  assign Hazard_Stall = load_use & ~Stall & ~Flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (Flush) begin
      ex_q <= '0;
    end else if (Stall) begin
      ex_q <= ex_q;
    end else if (Hazard_Stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB; r0 is never forwarded.
  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (EXMEM_RegWrite && (EXMEM_Rd != 5'd0) && (EXMEM_Rd == ex_q.rs)) begin
      rs_fwd = EXMEM_Result;
    end else if (MEMWB_RegWrite && (MEMWB_Rd != 5'd0) && (MEMWB_Rd == ex_q.rs)) begin
      rs_fwd = MEMWB_Result;
    end
  end

  always_comb begin
    rt_fwd = ex_q.rt_data;
    if (EXMEM_RegWrite && (EXMEM_Rd != 5'd0) && (EXMEM_Rd == ex_q.rt)) begin
      rt_fwd = EXMEM_Result;
    end else if (MEMWB_RegWrite && (MEMWB_Rd != 5'd0) && (MEMWB_Rd == ex_q.rt)) begin
      rt_fwd = MEMWB_Result;
    end
  end

  assign A             = rs_fwd;
  assign B             = ex_q.use_imm ? ex_q.imm : rt_fwd;
  assign ALU_Sel       = ex_q.alu_sel;
  assign Rd_Out        = ex_q.rd;
  assign Reg_Write_Out = ex_q.reg_write;
  assign Mem_Read_Out  = ex_q.mem_read;
  assign Valid_Out     = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected stage outputs are queued when stimulus is applied
// and popped for comparison once the stage register has captured it.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, Flush, In_Valid;
  logic [4:0]  Rs_Addr, Rt_Addr, Rd_Addr;
  logic [31:0] Rs_Data, Rt_Data, Imm;
  logic        Use_Imm;
  logic [3:0]  ALU_Sel_In;
  logic        Reg_Write_In, Mem_Read_In;
  logic        EXMEM_RegWrite, MEMWB_RegWrite;
  logic [4:0]  EXMEM_Rd, MEMWB_Rd;
  logic [31:0] EXMEM_Result, MEMWB_Result;
  logic [31:0] A, B;
  logic [3:0]  ALU_Sel;
  logic [4:0]  Rd_Out;
  logic        Reg_Write_Out, Mem_Read_Out, Valid_Out, Hazard_Stall;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        v;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  id_ex_stage #(.WIDTH(32), .OP_SZ(4)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Rd_Addr(Rd_Addr),
    .Rs_Data(Rs_Data), .Rt_Data(Rt_Data), .Imm(Imm), .Use_Imm(Use_Imm),
    .ALU_Sel_In(ALU_Sel_In), .Reg_Write_In(Reg_Write_In), .Mem_Read_In(Mem_Read_In),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_Rd(EXMEM_Rd), .EXMEM_Result(EXMEM_Result),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd), .MEMWB_Result(MEMWB_Result),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .Rd_Out(Rd_Out),
    .Reg_Write_Out(Reg_Write_Out), .Mem_Read_Out(Mem_Read_Out),
    .Valid_Out(Valid_Out), .Hazard_Stall(Hazard_Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] alu, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic v);
    exp_t e;
    e.a = a; e.b = b; e.alu = alu; e.rd = rd; e.rw = rw; e.mr = mr; e.v = v;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_zero(input string tag);
    push(tag, 32'h0, 32'h0, 4'h0, 5'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got no expected entry, want one");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".A"}, A, e.a);
      chk({t, ".B"}, B, e.b);
      chk({t, ".alu"}, 32'(ALU_Sel), 32'(e.alu));
      chk({t, ".rd"}, 32'(Rd_Out), 32'(e.rd));
      chk({t, ".rw"}, 32'(Reg_Write_Out), 32'(e.rw));
      chk({t, ".mr"}, 32'(Mem_Read_Out), 32'(e.mr));
      chk({t, ".v"}, 32'(Valid_Out), 32'(e.v));
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [31:0] imm, input logic ui, input logic [3:0] alu,
                           input logic rw, input logic mr);
    In_Valid = v; Rs_Addr = rs; Rt_Addr = rt; Rd_Addr = rd;
    Rs_Data = rsd; Rt_Data = rtd; Imm = imm; Use_Imm = ui;
    ALU_Sel_In = alu; Reg_Write_In = rw; Mem_Read_In = mr;
  endtask

  task automatic clear_fwd();
    EXMEM_RegWrite = 1'b0; EXMEM_Rd = 5'd0; EXMEM_Result = 32'h0;
    MEMWB_RegWrite = 1'b0; MEMWB_Rd = 5'd0; MEMWB_Result = 32'h0;
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    clear_fwd();

    // reset state
    step(); step();
    push_zero("reset");
    check_out();
    chk("reset.hz", 32'(Hazard_Stall), 32'd0);

    // plain load, first capture after reset release
    rst = 1'b0;
    set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd4, 32'd3, 32'h0, 1'b0, 4'd1, 1'b1, 1'b0);
    push("plain", 32'd4, 32'd3, 4'd1, 5'd3, 1'b1, 1'b0, 1'b1);
    step(); check_out();

    // immediate B operand wins over a matching Rt producer
    set_instr(1'b1, 5'd1, 5'd7, 5'd4, 32'hDEADBEEF, 32'd9, 32'h1234, 1'b1, 4'd2, 1'b1, 1'b0);
    EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd7; EXMEM_Result = 32'hAA;
    push("imm", 32'hDEADBEEF, 32'h1234, 4'd2, 5'd4, 1'b1, 1'b0, 1'b1);
    step(); check_out();

    // double forward on Rs, then Rt
    set_instr(1'b1, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 32'h0, 1'b0, 4'd2, 1'b1, 1'b0);
    EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd5; EXMEM_Result = 32'hAA;
    MEMWB_RegWrite = 1'b1; MEMWB_Rd = 5'd5; MEMWB_Result = 32'hBB;
    push("fwd_both", 32'hAA, 32'h22, 4'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    EXMEM_RegWrite = 1'b0; #1;
    push("fwd_memwb", 32'hBB, 32'h22, 4'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    check_out();
    EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd6; MEMWB_Rd = 5'd6; #1;
    push("fwd_rt_both", 32'h11, 32'hAA, 4'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    check_out();
    EXMEM_RegWrite = 1'b0; #1;
    push("fwd_rt_memwb", 32'h11, 32'hBB, 4'd2, 5'd8, 1'b1, 1'b0, 1'b1);
    check_out();

    // register 0 is never forwarded
    set_instr(1'b1, 5'd0, 5'd0, 5'd2, 32'h55, 32'h66, 32'h0, 1'b0, 4'd3, 1'b1, 1'b0);
    EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd0; EXMEM_Result = 32'hFF;
    MEMWB_RegWrite = 1'b1; MEMWB_Rd = 5'd0; MEMWB_Result = 32'hEE;
    push("r0_guard", 32'h55, 32'h66, 4'd3, 5'd2, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    clear_fwd();

    // load-use on Rs: bubble, then the retried instruction enters
    set_instr(1'b1, 5'd1, 5'd2, 5'd7, 32'h10, 32'h20, 32'h0, 1'b0, 4'd5, 1'b1, 1'b1);
    push("load", 32'h10, 32'h20, 4'd5, 5'd7, 1'b1, 1'b1, 1'b1);
    step(); check_out();
    set_instr(1'b1, 5'd7, 5'd3, 5'd9, 32'h70, 32'h30, 32'h0, 1'b0, 4'd6, 1'b1, 1'b0);
    #1 chk("hz_rs", 32'(Hazard_Stall), 32'd1);
    push_zero("bubble");
    step(); check_out();
    chk("hz_after_bubble", 32'(Hazard_Stall), 32'd0);
    push("retry", 32'h70, 32'h30, 4'd6, 5'd9, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    chk("hz_after_retry", 32'(Hazard_Stall), 32'd0);

    // load-use qualifiers on Rt
    set_instr(1'b1, 5'd1, 5'd2, 5'd7, 32'h10, 32'h20, 32'h0, 1'b0, 4'd5, 1'b1, 1'b1);
    push("load2", 32'h10, 32'h20, 4'd5, 5'd7, 1'b1, 1'b1, 1'b1);
    step(); check_out();
    set_instr(1'b1, 5'd1, 5'd7, 5'd9, 32'h1, 32'h2, 32'h40, 1'b1, 4'd6, 1'b1, 1'b0);
    #1 chk("hz_rt_imm", 32'(Hazard_Stall), 32'd0);
    Use_Imm = 1'b0;
    #1 chk("hz_rt", 32'(Hazard_Stall), 32'd1);
    Stall = 1'b1;
    #1 chk("hz_masked_stall", 32'(Hazard_Stall), 32'd0);
    Stall = 1'b0; Flush = 1'b1;
    #1 chk("hz_masked_flush", 32'(Hazard_Stall), 32'd0);
    Flush = 1'b0; In_Valid = 1'b0;
    #1 chk("hz_invalid_decode", 32'(Hazard_Stall), 32'd0);
    In_Valid = 1'b1; Flush = 1'b1;
    push_zero("flush");
    step(); check_out();
    Flush = 1'b0;

    // a load targeting r0 never raises a hazard
    set_instr(1'b1, 5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'h0, 1'b0, 4'd5, 1'b1, 1'b1);
    push("load_r0", 32'h10, 32'h20, 4'd5, 5'd0, 1'b1, 1'b1, 1'b1);
    step(); check_out();
    set_instr(1'b1, 5'd0, 5'd0, 5'd9, 32'h1, 32'h2, 32'h0, 1'b0, 4'd6, 1'b1, 1'b0);
    #1 chk("hz_r0", 32'(Hazard_Stall), 32'd0);

    // stall holds for two cycles, flush overrides stall
    set_instr(1'b1, 5'd11, 5'd12, 5'd10, 32'h31, 32'h32, 32'h0, 1'b0, 4'd3, 1'b1, 1'b0);
    push("hold_src", 32'h31, 32'h32, 4'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    Stall = 1'b1;
    set_instr(1'b1, 5'd13, 5'd14, 5'd15, 32'h99, 32'h98, 32'h97, 1'b1, 4'd7, 1'b0, 1'b1);
    push("stall1", 32'h31, 32'h32, 4'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    push("stall2", 32'h31, 32'h32, 4'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    Flush = 1'b1;
    push_zero("flush_stall");
    step(); check_out();
    Flush = 1'b0; Stall = 1'b0;

    // reset during a stall discards the held instruction
    set_instr(1'b1, 5'd11, 5'd12, 5'd10, 32'h31, 32'h32, 32'h0, 1'b0, 4'd3, 1'b1, 1'b0);
    push("hold_src2", 32'h31, 32'h32, 4'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    Stall = 1'b1;
    push("stall3", 32'h31, 32'h32, 4'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    step(); check_out();
    rst = 1'b1;
    push_zero("rst_stall");
    step(); check_out();
    chk("rst_stall.hz", 32'(Hazard_Stall), 32'd0);
    rst = 1'b0; Stall = 1'b0;
    set_instr(1'b1, 5'd3, 5'd4, 5'd5, 32'h123, 32'h456, 32'h0, 1'b0, 4'd9, 1'b0, 1'b0);
    push("post_rst", 32'h123, 32'h456, 4'd9, 5'd5, 1'b0, 1'b0, 1'b1);
    step(); check_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter WIDTH, 32, datapath width.
REQ-002 Parameter OP_SZ, 4, ALU select width.
REQ-003 One clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 Stall  in  1  external hold; Flush  in  1  squash EX contents.
REQ-005 In_Valid  in  1  decode slot holds a real instruction.
REQ-006 Rs_Addr, Rt_Addr, Rd_Addr  in  5 each  source/destination register numbers.
REQ-007 Rs_Data, Rt_Data, Imm  in  WIDTH each  register-file reads, sign-extended immediate.
REQ-008 Use_Imm  in  1  B operand is Imm; ALU_Sel_In  in  OP_SZ; Reg_Write_In, Mem_Read_In  in  1 each.
REQ-009 EXMEM_RegWrite  in  1; EXMEM_Rd  in  5; EXMEM_Result  in  WIDTH  one-ahead producer.
REQ-010 MEMWB_RegWrite  in  1; MEMWB_Rd  in  5; MEMWB_Result  in  WIDTH  two-ahead producer.
REQ-011 A, B  out  WIDTH  forwarded ALU operands; ALU_Sel  out  OP_SZ.
REQ-012 Rd_Out  out  5; Reg_Write_Out, Mem_Read_Out, Valid_Out  out  1 each.
REQ-013 Hazard_Stall  out  1  load-use hold request to fetch/decode.

Function
REQ-014 Stage register captures Rs/Rt/Rd addr, Rs/Rt data, Imm, Use_Imm, ALU_Sel_In, Reg_Write_In, Mem_Read_In, In_Valid on each rising clk edge.
REQ-015 Update priority per edge: rst > Flush > Stall > Hazard_Stall bubble > normal load.
REQ-016 Bubble/flush = all stored fields zero (Valid_Out=0, Reg_Write_Out=0, Mem_Read_Out=0, ALU_Sel=0, Rd_Out=0).
REQ-017 Stall=1 (no Flush): all stored fields hold value.
REQ-018 Flush=1 clears stage even when Stall=1.
REQ-019 Hazard_Stall combinational = In_Valid & Valid_Out & Mem_Read_Out & Rd_Out!=0 & (Rd_Out==Rs_Addr | (Rd_Out==Rt_Addr & !Use_Imm)).
REQ-020 Hazard_Stall=1, Stall=0, Flush=0: stage loads bubble; upstream holds; decoded instruction retried next cycle, then Hazard_Stall deasserts.
REQ-021 Hazard_Stall is forced 0 while Stall=1 or Flush=1.
REQ-022 Forwarding combinational on registered addresses; latency input-to-A/B one cycle.
REQ-023 Rs forward: if EXMEM_RegWrite & EXMEM_Rd!=0 & EXMEM_Rd==rs_q -> EXMEM_Result; else if MEMWB_RegWrite & MEMWB_Rd!=0 & MEMWB_Rd==rs_q -> MEMWB_Result; else rs_data_q.
REQ-024 Rt forward identical using rt_q; EXMEM wins when both match.
REQ-025 A = forwarded Rs; B = Imm_q if Use_Imm_q else forwarded Rt.
REQ-026 Register 0 never forwarded; rs_q=0 yields stored data regardless of producers.
REQ-027 Forwarding applies when Valid_Out=0 (bubble yields zero addr -> no forward, A=B=0).
REQ-028 No arithmetic in block; operand values passed bit-exact, WIDTH bits.

Reset
REQ-029 rst=1 at edge: all stored fields zero; A=B=0, ALU_Sel=0, Rd_Out=0, Reg_Write_Out=Mem_Read_Out=Valid_Out=0, Hazard_Stall=0 (given producer inputs deasserted).
REQ-030 rst overrides Stall and Flush; reset mid-stall discards held instruction.
REQ-031 First valid capture is the edge after rst falls.

Verification
REQ-032 Plain load: Rs_Data=4, Rt_Data=3, ALU_Sel_In=1, no producers -> next cycle A=4, B=3, ALU_Sel=1, Valid_Out=1.
REQ-033 Double forward: rs_q=5, EXMEM_Rd=5 result 0xAA, MEMWB_Rd=5 result 0xBB, both RegWrite -> A=0xAA; drop EXMEM_RegWrite -> A=0xBB.
REQ-034 R0 guard: rs_q=0, EXMEM_Rd=0, EXMEM_RegWrite=1, result 0xFF -> A=stored Rs_Data, not 0xFF.
REQ-035 Load-use: EX holds Mem_Read, Rd_Out=7; decode Rs_Addr=7 -> Hazard_Stall=1, next cycle Valid_Out=0, Hazard_Stall=0; Use_Imm=1 with Rt_Addr=7 only -> Hazard_Stall=0.
REQ-036 Stall/Flush/rst: Stall=1 two cycles -> outputs frozen; Flush with Stall -> Valid_Out=0 next cycle; rst mid-stall -> all outputs zero.
